// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
// Shared definitions for the fetch queue:
//   - FQ_* localparams: default geometry used by the core top
//   - cnt_op_e:         occupancy-update action selected each cycle
//   - fq_cnt_op():      maps flush/push/pop to a cnt_op_e
package fetch_queue_pkg;

    localparam int FQ_DEPTH      = 4;
    localparam int FQ_SKID       = 2;
    localparam int FQ_INST_WIDTH = 32;
    localparam int FQ_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_INC  = 2'b01,
        CNT_DEC  = 2'b10,
        CNT_CLR  = 2'b11
    } cnt_op_e;

    // Flush dominates; a simultaneous push and pop leaves occupancy unchanged.
    function automatic cnt_op_e fq_cnt_op(input logic flush, input logic push, input logic pop);
        cnt_op_e op;
        if (flush) begin
            op = CNT_CLR;
        end else if (push && !pop) begin
            op = CNT_INC;
        end else if (pop && !push) begin
            op = CNT_DEC;
        end else begin
            op = CNT_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// fq_storage
// Entry array for the fetch queue: one synchronous write port and one
// combinational read port. Contents are intentionally not reset; validity
// is tracked entirely by the control logic in fetch_queue.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write index
//   wdata  - write data
//   raddr  - read index
//   rdata  - combinational read data at raddr
module fq_storage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// Circular instruction buffer between Fetch and Decode with a
// first-word-fall-through head, an early stall request to Fetch and a
// sticky overflow flag. A branch flush empties the queue on the next edge.
// Ports:
//   clk             - clock, all state on rising edge
//   reset           - asynchronous active-low reset
//   opcode_in       - instruction from Fetch
//   pc_in           - PC of opcode_in
//   uop_valid_in    - push strobe from Fetch
//   system_flush    - synchronous branch flush
//   system_stall    - global pipeline stall (blocks pop, not push)
//   decode_ready    - Decode accepts the head entry
//   inst_out        - head instruction
//   pc_out          - head PC
//   inst_valid_out  - head entry is valid for Decode
//   fetch_stall_req - occupancy at or above DEPTH-SKID
//   count           - occupancy
//   overflow_err    - sticky: a push was dropped
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH      = FQ_DEPTH,
    parameter int SKID       = FQ_SKID,
    parameter int INST_WIDTH = FQ_INST_WIDTH,
    parameter int ADDR_WIDTH = FQ_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [INST_WIDTH-1:0]      opcode_in,
    input  logic [ADDR_WIDTH-1:0]      pc_in,
    input  logic                       uop_valid_in,
    input  logic                       system_flush,
    input  logic                       system_stall,
    input  logic                       decode_ready,
    output logic [INST_WIDTH-1:0]      inst_out,
    output logic [ADDR_WIDTH-1:0]      pc_out,
    output logic                       inst_valid_out,
    output logic                       fetch_stall_req,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = INST_WIDTH + ADDR_WIDTH;

    logic [PW-1:0] wr_ptr_r, wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_r, rd_ptr_nxt_s;
    logic [CW-1:0] count_r, count_nxt_s;
    logic          overflow_r, overflow_nxt_s;

    logic          full_s, empty_s, valid_s, push_s, pop_s, drop_s;
    cnt_op_e       cnt_op_s;
    logic [EW-1:0] rd_data_s;

    // Handshake decode and next-state computation
    always_comb begin
        full_s         = (count_r == CW'(DEPTH));
        empty_s        = (count_r == CW'(0));
        valid_s        = !empty_s && !system_stall && !system_flush;
        pop_s          = valid_s && decode_ready;
        // A pop frees the slot in the same cycle, so a full queue still accepts.
        push_s         = uop_valid_in && !system_flush && (!full_s || pop_s);
        drop_s         = uop_valid_in && full_s && !pop_s && !system_flush;
        cnt_op_s       = fq_cnt_op(system_flush, push_s, pop_s);
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        count_nxt_s    = count_r;
        overflow_nxt_s = overflow_r | drop_s;

        if (system_flush) begin
            wr_ptr_nxt_s = {PW{1'b0}};
            rd_ptr_nxt_s = {PW{1'b0}};
        end else begin
            // Power-of-two depth: pointers wrap by plain overflow.
            wr_ptr_nxt_s = push_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
            rd_ptr_nxt_s = pop_s  ? rd_ptr_r + PW'(1) : rd_ptr_r;
        end

        case (cnt_op_s)
            CNT_INC:  count_nxt_s = count_r + CW'(1);
            CNT_DEC:  count_nxt_s = count_r - CW'(1);
            CNT_CLR:  count_nxt_s = {CW{1'b0}};
            CNT_HOLD: count_nxt_s = count_r;
            default:  count_nxt_s = count_r;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_storage (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata ({opcode_in, pc_in}),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    assign inst_out        = rd_data_s[EW-1:ADDR_WIDTH];
    assign pc_out          = rd_data_s[ADDR_WIDTH-1:0];
    assign inst_valid_out  = valid_s;
    assign count           = count_r;
    assign overflow_err    = overflow_r;
    assign fetch_stall_req = (count_r >= CW'(DEPTH - SKID));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Self-checking bench for fetch_queue (DEPTH=4, SKID=2). Directed scenario
// tasks followed by a randomized run against a queue-based reference model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] opcode_in;
    logic [31:0] pc_in;
    logic        uop_valid_in;
    logic        system_flush;
    logic        system_stall;
    logic        decode_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid_out;
    logic        fetch_stall_req;
    logic [2:0]  count;
    logic        overflow_err;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {inst, pc}, oldest at the front
    logic [63:0] mq [$];
    logic        m_ovf = 1'b0;

    fetch_queue dut (
        .clk             (clk),
        .reset           (reset),
        .opcode_in       (opcode_in),
        .pc_in           (pc_in),
        .uop_valid_in    (uop_valid_in),
        .system_flush    (system_flush),
        .system_stall    (system_stall),
        .decode_ready    (decode_ready),
        .inst_out        (inst_out),
        .pc_out          (pc_out),
        .inst_valid_out  (inst_valid_out),
        .fetch_stall_req (fetch_stall_req),
        .count           (count),
        .overflow_err    (overflow_err)
    );

    always #5 clk = ~clk;

    // Apply one clock edge to the reference model using the current inputs.
    task automatic model_edge();
        bit mv, mp, can_push;
        mv = (mq.size() != 0) && !system_stall && !system_flush;
        mp = mv && decode_ready;
        if (system_flush) begin
            mq.delete();
        end else begin
            can_push = uop_valid_in && ((mq.size() < 4) || mp);
            if (uop_valid_in && !can_push) m_ovf = 1'b1;
            if (mp) void'(mq.pop_front());
            if (can_push) mq.push_back({opcode_in, pc_in});
        end
    endtask

    // Drive one cycle of inputs, clock it, then return inputs to idle.
    task automatic step(input logic v, input logic [31:0] op, input logic [31:0] pc,
                        input logic fl, input logic st, input logic rdy);
        uop_valid_in = v;  opcode_in = op;  pc_in = pc;
        system_flush = fl; system_stall = st; decode_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        uop_valid_in = 1'b0; system_flush = 1'b0; system_stall = 1'b0; decode_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        uop_valid_in = 1'b0; system_flush = 1'b0; system_stall = 1'b0; decode_ready = 1'b0;
        opcode_in = 32'h0; pc_in = 32'h0;
        #12;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (inst_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid_out); end
        total++; if (fetch_stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall_req got=%b exp=0", fetch_stall_req); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow_err); end
        reset = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_first_push();
        step(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (inst_valid_out !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", inst_valid_out); end
        total++; if (inst_out !== 32'h00500093) begin bad++; $display("FAIL first_inst got=%h exp=00500093", inst_out); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL first_pc got=%h exp=0", pc_out); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL first_count got=%0d exp=1", count); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL first_drain got=%0d exp=0", count); end
        // Empty + push + ready: push only, entry seen next cycle
        step(1'b1, 32'h00000044, 32'h44, 1'b0, 1'b0, 1'b1);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL empty_push_pop_count got=%0d exp=1", count); end
        total++; if (pc_out !== 32'h44) begin bad++; $display("FAIL empty_push_pop_pc got=%h exp=44", pc_out); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        total++; if (inst_valid_out !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", inst_valid_out); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h100 + i, 32'(i * 4), 1'b0, 1'b0, 1'b0);
            total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
            total++; if (fetch_stall_req !== (i + 1 >= 2)) begin bad++; $display("FAIL fill_stall_req got=%b exp=%b", fetch_stall_req, (i + 1 >= 2)); end
        end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got=%b exp=0", overflow_err); end
        step(1'b1, 32'h199, 32'h99, 1'b0, 1'b0, 1'b0);
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL overflow_flag got=%b exp=1", overflow_err); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL overflow_count got=%0d exp=4", count); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL overflow_head got=%h exp=0", pc_out); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_pc   [4];
        logic [31:0] exp_inst [4];
        exp_pc   = '{32'h4, 32'h8, 32'hC, 32'h10};
        exp_inst = '{32'h101, 32'h102, 32'h103, 32'h110};
        step(1'b1, 32'h110, 32'h10, 1'b0, 1'b0, 1'b1);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_pushpop_count got=%0d exp=4", count); end
        for (int k = 0; k < 4; k++) begin
            total++; if (inst_valid_out !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b exp=1", k, inst_valid_out); end
            total++; if (pc_out !== exp_pc[k]) begin bad++; $display("FAIL drain_pc[%0d] got=%h exp=%h", k, pc_out, exp_pc[k]); end
            total++; if (inst_out !== exp_inst[k]) begin bad++; $display("FAIL drain_inst[%0d] got=%h exp=%h", k, inst_out, exp_inst[k]); end
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL drained_count got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h114 + 4 * i, 32'h14 + 4 * i, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        step(1'b1, 32'h120, 32'h20, 1'b1, 1'b0, 1'b0);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (inst_valid_out !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", inst_valid_out); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        total++; if (inst_valid_out !== 1'b0) begin bad++; $display("FAIL flush_no_entry got=%b exp=0", inst_valid_out); end
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL flush_ovf_sticky got=%b exp=1", overflow_err); end
    endtask

    task automatic test_stall();
        step(1'b1, 32'h124, 32'h24, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h128, 32'h28, 1'b0, 1'b0, 1'b0);
        system_stall = 1'b1; decode_ready = 1'b1; #1;
        total++; if (inst_valid_out !== 1'b0) begin bad++; $display("FAIL stall_valid got=%b exp=0", inst_valid_out); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL stall_count got=%0d exp=2", count); end
        step(1'b1, 32'h130, 32'h30, 1'b0, 1'b1, 1'b1);
        total++; if (count !== 3'd3) begin bad++; $display("FAIL stall_push_count got=%0d exp=3", count); end
        decode_ready = 1'b1; #1;
        total++; if (inst_valid_out !== 1'b1) begin bad++; $display("FAIL unstall_valid got=%b exp=1", inst_valid_out); end
        total++; if (pc_out !== 32'h24) begin bad++; $display("FAIL unstall_pc got=%h exp=24", pc_out); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL unstall_count got=%0d exp=2", count); end
        total++; if (pc_out !== 32'h28) begin bad++; $display("FAIL unstall_next_pc got=%h exp=28", pc_out); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL areset_count got=%0d exp=0", count); end
        total++; if (inst_valid_out !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", inst_valid_out); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL areset_ovf got=%b exp=0", overflow_err); end
        total++; if (fetch_stall_req !== 1'b0) begin bad++; $display("FAIL areset_stall_req got=%b exp=0", fetch_stall_req); end
        mq.delete();
        m_ovf = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_random();
        logic [63:0] head;
        bit          exp_valid;
        for (int n = 0; n < 400; n++) begin
            uop_valid_in = ($urandom_range(0, 9) < 7);
            opcode_in    = $urandom;
            pc_in        = $urandom & 32'hFFFF_FFFC;
            system_flush = ($urandom_range(0, 19) == 0);
            system_stall = ($urandom_range(0, 3) == 0);
            decode_ready = ($urandom_range(0, 9) < 5);
            #1;
            exp_valid = (mq.size() != 0) && !system_stall && !system_flush;
            total++; if (inst_valid_out !== exp_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, inst_valid_out, exp_valid); end
            if (mq.size() != 0) begin
                head = mq[0];
                total++; if ({inst_out, pc_out} !== head) begin bad++; $display("FAIL rnd_head[%0d] got=%h exp=%h", n, {inst_out, pc_out}, head); end
            end
            total++; if (count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, count, mq.size()); end
            total++; if (fetch_stall_req !== (mq.size() >= 2)) begin bad++; $display("FAIL rnd_stall_req[%0d] got=%b exp=%b", n, fetch_stall_req, (mq.size() >= 2)); end
            total++; if (overflow_err !== m_ovf) begin bad++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", n, overflow_err, m_ovf); end
            @(posedge clk);
            model_edge();
            #2;
        end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill_overflow();
        test_full_push_pop();
        test_flush();
        test_stall();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
